// File: rtl/proc_control_unit.sv
// proc_control_unit: T0-T3 step sequencer and instruction decoder for the multicycle processor.
// Drives every datapath load enable and bus select from the step register, IR and Run.
module proc_control_unit (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       AddSub,
    output logic       Done,
    output logic [1:0] Tstep
);
    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    step_t      step_q, step_d;
    logic [2:0] opcode;
    logic [7:0] x_sel, y_sel;
    logic       arith;

    assign opcode = IR[8:6];
    assign x_sel  = 8'd1 << IR[5:3];
    assign y_sel  = 8'd1 << IR[2:0];
    assign arith  = (opcode[2:1] == 2'b01);
    assign Tstep  = step_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) step_q <= T0;
        else         step_q <= step_d;
    end

    always_comb begin
        IRin   = 1'b0;
        Rin    = 8'd0;
        Rout   = 8'd0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        case (step_q)
            T0: IRin = Run;
            T1: begin
                if (opcode == 3'b000) begin
                    Rout = y_sel;
                    Rin  = x_sel;
                    Done = 1'b1;
                end else if (opcode == 3'b001) begin
                    DINout = 1'b1;
                    Rin    = x_sel;
                    Done   = 1'b1;
                end else if (arith) begin
                    Rout = x_sel;
                    Ain  = 1'b1;
                end else begin
                    Done = 1'b1;
                end
            end
            T2: begin
                // A non-arith opcode here means IR changed under us; just retire.
                if (arith) begin
                    Rout   = y_sel;
                    Gin    = 1'b1;
                    AddSub = opcode[0];
                end else begin
                    Done = 1'b1;
                end
            end
            default: begin
                if (arith) begin
                    Gout = 1'b1;
                    Rin  = x_sel;
                end
                Done = 1'b1;
            end
        endcase
        if (step_q == T0) step_d = Run ? T1 : T0;
        else              step_d = Done ? T0 : step_t'(step_q + 2'd1);
        // Reset masks every output, including the Run-derived IRin.
        if (!Resetn) begin
            IRin   = 1'b0;
            Rin    = 8'd0;
            Rout   = 8'd0;
            DINout = 1'b0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            Gout   = 1'b0;
            AddSub = 1'b0;
            Done   = 1'b0;
        end
    end
endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit: directed scoreboard bench for the control FSM outputs.
module tb_proc_control_unit;
    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Run = 1'b0;
    logic [8:0] IR = 9'd0;
    logic       IRin, DINout, Ain, Gin, Gout, AddSub, Done;
    logic [7:0] Rin, Rout;
    logic [1:0] Tstep;

    int tests = 0;
    int fails = 0;
    logic [24:0] exp_q[$];
    string       tag_q[$];

    proc_control_unit dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .AddSub(AddSub),
        .Done(Done), .Tstep(Tstep)
    );

    always #5 Clock = ~Clock;

    function automatic logic [24:0] ev(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                       input logic din, input logic ain, input logic gin, input logic gout,
                                       input logic as, input logic done, input logic [1:0] t);
        return {irin, rin, rout, din, ain, gin, gout, as, done, t};
    endfunction

    task automatic expect_out(input logic [24:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        logic [24:0] got, e;
        string tag;
        got = {IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done, Tstep};
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        tests++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, e);
        end
        tests++;
        assert (($countones(Rout) + 32'(Gout) + 32'(DINout)) <= 1) else begin
            fails++;
            $error("FAIL %s bus_onehot: observed Rout=%h Gout=%b DINout=%b expected at most one driver", tag, Rout, Gout, DINout);
        end
        tests++;
        assert ($countones(Rin) <= 1) else begin
            fails++;
            $error("FAIL %s rin_onehot: observed Rin=%h expected zero/one-hot", tag, Rin);
        end
    endtask

    task automatic cyc(input logic run, input logic [8:0] ir, input logic [24:0] e, input string tag);
        Run = run;
        IR  = ir;
        expect_out(e, tag);
        @(negedge Clock);
        check();
        @(posedge Clock);
        #1;
    endtask

    localparam logic [24:0] IDLE = 25'd0;

    initial begin
        Run = 1'b1;
        #1;
        expect_out(IDLE, "reset_masks_run");
        check();
        @(posedge Clock);
        #1;
        expect_out(IDLE, "reset_hold");
        check();
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 9'h000, IDLE, "idle_t0");
        // mvi R0
        cyc(1'b1, 9'h040, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "mvi_t0");
        cyc(1'b0, 9'h040, ev(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1), "mvi_t1");
        cyc(1'b0, 9'h040, IDLE, "mvi_back_t0");
        // add R0,R1 with Run dropped mid-instruction
        cyc(1'b1, 9'h081, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "add_t0");
        cyc(1'b0, 9'h081, ev(0, 8'h00, 8'h01, 0, 1, 0, 0, 0, 0, 2'd1), "add_t1");
        cyc(1'b0, 9'h081, ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 2'd2), "add_t2");
        cyc(1'b0, 9'h081, ev(0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3), "add_t3");
        cyc(1'b0, 9'h081, IDLE, "add_back_t0");
        // sub R2,R3 then mv R5,R7 with Run held high
        cyc(1'b1, 9'h0D3, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "sub_t0");
        cyc(1'b1, 9'h0D3, ev(0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 2'd1), "sub_t1");
        cyc(1'b1, 9'h0D3, ev(0, 8'h00, 8'h08, 0, 0, 1, 0, 1, 0, 2'd2), "sub_t2");
        cyc(1'b1, 9'h0D3, ev(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3), "sub_t3");
        cyc(1'b1, 9'h02F, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "mv_b2b_t0");
        cyc(1'b1, 9'h02F, ev(0, 8'h20, 8'h80, 0, 0, 0, 0, 0, 1, 2'd1), "mv_b2b_t1");
        cyc(1'b0, 9'h02F, IDLE, "mv_back_t0");
        // undefined opcode
        cyc(1'b1, 9'h1C0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "undef_t0");
        cyc(1'b0, 9'h1C0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1), "undef_t1");
        cyc(1'b0, 9'h1C0, IDLE, "undef_back_t0");
        // X == Y cases
        cyc(1'b1, 9'h01B, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "mv33_t0");
        cyc(1'b0, 9'h01B, ev(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 2'd1), "mv33_t1");
        cyc(1'b1, 9'h09B, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "add33_t0");
        cyc(1'b0, 9'h09B, ev(0, 8'h00, 8'h08, 0, 1, 0, 0, 0, 0, 2'd1), "add33_t1");
        cyc(1'b0, 9'h09B, ev(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 2'd2), "add33_t2");
        cyc(1'b0, 9'h09B, ev(0, 8'h08, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3), "add33_t3");
        // async reset during T2 of add
        cyc(1'b1, 9'h081, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "rst_add_t0");
        cyc(1'b0, 9'h081, ev(0, 8'h00, 8'h01, 0, 1, 0, 0, 0, 0, 2'd1), "rst_add_t1");
        expect_out(ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 2'd2), "rst_add_t2");
        @(negedge Clock);
        check();
        #2;
        Resetn = 1'b0;
        #1;
        expect_out(IDLE, "rst_async_clear");
        check();
        @(posedge Clock);
        #1;
        expect_out(IDLE, "rst_no_t3");
        check();
        Resetn = 1'b1;
        cyc(1'b0, 9'h081, IDLE, "post_rst_idle");
        cyc(1'b1, 9'h040, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "post_rst_t0");
        cyc(1'b0, 9'h040, ev(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1), "post_rst_t1");
        cyc(1'b0, 9'h040, IDLE, "post_rst_back_t0");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
